mem_ctrl: RTL and testbench
===========================

// Module: mem_ctrl
// PURPOSE
//  Responder for the MEM-stage load/store request interface and for instruction-fetch reads.
//  Serialises each 1/2/4-byte request onto the byte-wide RAM/IO bus, little-endian.
//  Returns a one-cycle done pulse plus read data. Reports busy state so requesters hold off.
// PARAMETERS
//  ADDR_W       32  address width on every port
//  IO_ADDR_BIT  17  addr bit that selects the IO space (used only with MEMCTRL_IO_STALL_EN)
// PORTS
//  clk_in               in   1   clock, rising edge
//  rst_in               in   1   reset; asynchronous, active-high
//  rdy_in               in   1   0 = freeze all state, force mem_wr=0
//  read_mem             in   1   MEM load request (level; held until mem_load_done)
//  write_mem            in   1   MEM store request (level)
//  mem_addr_to_read     in   32  MEM byte address (loads and stores)
//  mem_data_to_write    in   32  store data; byte k = bits[8k+7:8k]
//  data_len             in   3   load: byte count 1/2/4; store: count-1 (0/1/3)
//  mem_load_done        out  1   one-cycle done pulse for a MEM load or store
//  mem_ctrl_busy_state  out  2   [1] controller not IDLE; [0] serving fetch
//  mem_ctrl_read_in     out  32  zero-extended load data; valid while mem_load_done=1
//  if_read              in   1   fetch request, always 4 bytes
//  if_addr              in   32  fetch address
//  clear_in             in   1   pipeline flush; abort any fetch in progress
//  if_done              out  1   one-cycle fetch done pulse
//  if_data              out  32  instruction word; valid while if_done=1
//  mem_din              in   8   RAM/IO read byte
//  mem_dout             out  8   RAM/IO write byte
//  mem_a                out  32  RAM/IO byte address
//  mem_wr               out  1   1 = write mem_dout to mem_a
//  io_buffer_full       in   1   UART TX full (used only with MEMCTRL_IO_STALL_EN)
// BEHAVIOUR
//  Reset values: all outputs 0; state IDLE; byte counter 0.
//  All outputs are registered. Register updates occur only when rdy_in=1.
//  States: IDLE, READ, WRITE. A request is accepted only in IDLE, when no done pulse is high.
//  Arbitration in IDLE: write_mem > read_mem > if_read. Both MEM requests set =1 is illegal.
//  If if_read and clear_in are both high in IDLE, the fetch is not accepted.
//  Length: store count = data_len+1. Load and fetch count = data_len and 4 respectively.
//  Read (N bytes, accept edge E0):
//   - mem_a=A+k, mem_wr=0 is driven from edge Ek.
//   - mem_din holds byte(A+k) during the following cycle; it is captured at edge E(k+2).
//   - Done is set at E(N+1). Latency from accept to done-high is N+1 cycles.
//  Write (N bytes):
//   - mem_a=A+k, mem_dout=byte k, mem_wr=1 from edge Ek.
//   - At E(N): mem_wr drops and done is set.
//  Done pulse: exactly one cycle, with state back in IDLE. Data outputs hold until the next accept.
//   - mem_ctrl_read_in bytes above N are 0; the MEM stage sign-extends.
//  busy_state[1]=1 in READ/WRITE, including the capture-only cycle. It is 0 in IDLE and in the done cycle.
//  clear_in while serving a fetch:
//   - Return to IDLE next edge; no if_done.
//   - mem_a/mem_wr are left idle (mem_wr=0).
//   - MEM operations ignore clear_in.
//  Address wrap: A+k is computed modulo 2^ADDR_W.
//  rdy_in=0 mid-operation: counter and captured bytes are held; the operation resumes with no byte lost.
//  Async reset mid-operation:
//   - Immediate IDLE with mem_wr=0.
//   - Any partial store is abandoned; partial data is not completed.
// CONFIGURATION
//  MEMCTRL_IO_STALL_EN defined:
//   - A store byte with mem_a[IO_ADDR_BIT]=1 is not issued (mem_wr=0, counter held) while io_buffer_full=1.
//   - Issue resumes the cycle after io_buffer_full falls.
//  Not defined: io_buffer_full is ignored; IO stores proceed back-to-back.
// STRUCTURE
//  Shared package (define.v):
//   - state encodings (IDLE/READ/WRITE), `RstEnable, `True/`False.
//   - data_len encoding constants, IO address bit.
//  Single module; no sub-module. Byte counter and byte-lane mux are inline.
// TESTING
//  1. LW 0x1000 with RAM bytes 11,22,33,44:
//     -> done 5 cycles after accept; read_in=0x44332211; mem_a 0x1000..0x1003.
//  2. SH 0x2002, data 0xAABBCCDD, data_len=1:
//     -> writes DD@0x2002, CC@0x2003; done 1 cycle after last write; mem_wr=0 afterwards.
//  3. if_read and read_mem (LB 0x10) together in IDLE:
//     -> LB served first, read_in=0x000000xx, busy_state=2'b10; fetch then served, busy_state=2'b11.
//  4. clear_in during the 3rd byte of a fetch:
//     -> no if_done; IDLE next cycle; a new if_read 0x0 is accepted and completes normally.
//  5. rdy_in=0 for 3 cycles mid-LW:
//     -> same result as scenario 1, delayed by exactly 3 cycles.
//  6. MEMCTRL_IO_STALL_EN, SB 0x30000 with io_buffer_full=1 for 4 cycles:
//     -> mem_wr held 0 for 4 cycles, then one write; done the next cycle.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory controller: FSM state encoding, reset and
// boolean levels, data_len encodings and the default IO address-space bit.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRead  = 2'b01,
    StWrite = 2'b10
  } mem_state_e;

  localparam logic RstEnable = 1'b1;
  localparam logic True      = 1'b1;
  localparam logic False     = 1'b0;

  // Loads carry the byte count; stores carry count-1.
  localparam logic [2:0] LoadLenByte  = 3'd1;
  localparam logic [2:0] LoadLenHalf  = 3'd2;
  localparam logic [2:0] LoadLenWord  = 3'd4;
  localparam logic [2:0] StoreLenByte = 3'd0;
  localparam logic [2:0] StoreLenHalf = 3'd1;
  localparam logic [2:0] StoreLenWord = 3'd3;
  localparam logic [2:0] FetchLen     = 3'd4;

  localparam int unsigned IoAddrBit = 17;

  // Little-endian byte lane select.
  function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] idx);
    return word[8*idx +: 8];
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller for MEM-stage loads/stores and instruction
// fetch. Each 1/2/4-byte request is issued one byte per cycle on the RAM/IO
// bus (little-endian); a one-cycle done pulse returns the assembled data.
// Optional build macro MEMCTRL_IO_STALL_EN: hold IO-space store bytes while
// the UART TX buffer reports full.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned IO_ADDR_BIT = IoAddrBit
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              read_mem,
  input  logic              write_mem,
  input  logic [ADDR_W-1:0] mem_addr_to_read,
  input  logic [31:0]       mem_data_to_write,
  input  logic [2:0]        data_len,
  output logic              mem_load_done,
  output logic [1:0]        mem_ctrl_busy_state,
  output logic [31:0]       mem_ctrl_read_in,
  input  logic              if_read,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              clear_in,
  output logic              if_done,
  output logic [31:0]       if_data,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full
);

  mem_state_e        state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [2:0]        len_q, len_d;
  logic              fetch_q, fetch_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] mem_a_q, mem_a_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       read_in_q, read_in_d;
  logic [31:0]       if_data_q, if_data_d;
  logic [7:0]        dout_q, dout_d;
  logic              wr_q, wr_d;
  logic              load_done_q, load_done_d;
  logic              if_done_q, if_done_d;
  logic [1:0]        busy_q, busy_d;

  logic [ADDR_W-1:0] issue_addr;
  logic [1:0]        cap_lane;
  logic              accept_stall;
  logic              run_stall;

  // Byte k of the current request lives at base+k; wraps modulo 2^ADDR_W.
  assign issue_addr = base_q + ADDR_W'(cnt_q);
  // In READ the byte captured at edge k belongs to the address issued two edges earlier.
  assign cap_lane   = 2'(cnt_q - 3'd2);

`ifdef MEMCTRL_IO_STALL_EN
  assign accept_stall = mem_addr_to_read[IO_ADDR_BIT] & io_buffer_full;
  assign run_stall    = issue_addr[IO_ADDR_BIT] & io_buffer_full;
`else
  logic unused_io;
  assign accept_stall = 1'b0;
  assign run_stall    = 1'b0;
  assign unused_io    = io_buffer_full ^ issue_addr[IO_ADDR_BIT];
`endif

  // Next-state logic: accept/arbitrate in IDLE, step the byte counter in READ/WRITE.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    fetch_d     = fetch_q;
    base_d      = base_q;
    mem_a_d     = mem_a_q;
    wdata_d     = wdata_q;
    read_in_d   = read_in_q;
    if_data_d   = if_data_q;
    dout_d      = dout_q;
    wr_d        = wr_q;
    load_done_d = False;
    if_done_d   = False;

    unique case (state_q)
      StIdle: begin
        // Never accept while a done pulse is visible; the requester has not yet dropped.
        if (!load_done_q && !if_done_q) begin
          if (write_mem) begin
            state_d = StWrite;
            base_d  = mem_addr_to_read;
            wdata_d = mem_data_to_write;
            len_d   = data_len + 3'd1;
            fetch_d = False;
            mem_a_d = mem_addr_to_read;
            if (accept_stall) begin
              wr_d  = False;
              cnt_d = 3'd0;
            end else begin
              dout_d = mem_data_to_write[7:0];
              wr_d   = True;
              cnt_d  = 3'd1;
            end
          end else if (read_mem) begin
            state_d   = StRead;
            base_d    = mem_addr_to_read;
            len_d     = data_len;
            fetch_d   = False;
            mem_a_d   = mem_addr_to_read;
            wr_d      = False;
            cnt_d     = 3'd1;
            read_in_d = '0;
          end else if (if_read && !clear_in) begin
            state_d   = StRead;
            base_d    = if_addr;
            len_d     = FetchLen;
            fetch_d   = True;
            mem_a_d   = if_addr;
            wr_d      = False;
            cnt_d     = 3'd1;
            if_data_d = '0;
          end
        end
      end

      StRead: begin
        if (fetch_q && clear_in) begin
          // Flush abandons the fetch silently.
          state_d = StIdle;
          fetch_d = False;
          cnt_d   = 3'd0;
          wr_d    = False;
        end else begin
          if (cnt_q < len_q) begin
            mem_a_d = issue_addr;
          end
          if (cnt_q >= 3'd2) begin
            if (fetch_q) begin
              if_data_d[8*cap_lane +: 8] = mem_din;
            end else begin
              read_in_d[8*cap_lane +: 8] = mem_din;
            end
          end
          if (cnt_q == len_q + 3'd1) begin
            state_d = StIdle;
            cnt_d   = 3'd0;
            fetch_d = False;
            if (fetch_q) begin
              if_done_d = True;
            end else begin
              load_done_d = True;
            end
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end

      StWrite: begin
        if (cnt_q == len_q) begin
          wr_d        = False;
          state_d     = StIdle;
          cnt_d       = 3'd0;
          load_done_d = True;
        end else begin
          mem_a_d = issue_addr;
          if (run_stall) begin
            wr_d = False;
          end else begin
            dout_d = byte_lane(wdata_q, cnt_q[1:0]);
            wr_d   = True;
            cnt_d  = cnt_q + 3'd1;
          end
        end
      end

      default: begin
        state_d = StIdle;
        wr_d    = False;
        cnt_d   = 3'd0;
      end
    endcase

    busy_d = {state_d != StIdle, fetch_d};
  end

  // State and output registers; everything freezes while rdy_in is low.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in == RstEnable) begin
      state_q     <= StIdle;
      cnt_q       <= 3'd0;
      len_q       <= 3'd0;
      fetch_q     <= 1'b0;
      base_q      <= '0;
      mem_a_q     <= '0;
      wdata_q     <= '0;
      read_in_q   <= '0;
      if_data_q   <= '0;
      dout_q      <= '0;
      wr_q        <= 1'b0;
      load_done_q <= 1'b0;
      if_done_q   <= 1'b0;
      busy_q      <= 2'b00;
    end else if (rdy_in) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      fetch_q     <= fetch_d;
      base_q      <= base_d;
      mem_a_q     <= mem_a_d;
      wdata_q     <= wdata_d;
      read_in_q   <= read_in_d;
      if_data_q   <= if_data_d;
      dout_q      <= dout_d;
      wr_q        <= wr_d;
      load_done_q <= load_done_d;
      if_done_q   <= if_done_d;
      busy_q      <= busy_d;
    end
  end

  assign mem_load_done       = load_done_q;
  assign if_done             = if_done_q;
  assign mem_ctrl_busy_state = busy_q;
  assign mem_ctrl_read_in    = read_in_q;
  assign if_data             = if_data_q;
  assign mem_a               = mem_a_q;
  assign mem_dout            = dout_q;
  // A paused store byte must not hit the bus repeatedly.
  assign mem_wr              = wr_q & rdy_in;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: synchronous byte RAM model, scoreboard of
// expected done pulses/data, one task per scenario.
module tb_mem_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, read_mem, write_mem, if_read, clear_in, io_buffer_full;
  logic [31:0] mem_addr_to_read, mem_data_to_write, if_addr;
  logic [2:0]  data_len;
  logic        mem_load_done, if_done, mem_wr;
  logic [1:0]  mem_ctrl_busy_state;
  logic [31:0] mem_ctrl_read_in, if_data, mem_a;
  logic [7:0]  mem_din, mem_dout;

  int checks = 0;
  int passes = 0;

  typedef struct packed {
    logic        is_fetch;
    logic        chk;
    logic [31:0] data;
  } exp_t;

  exp_t        sb_q[$];
  logic [7:0]  ram [65536];
  logic [7:0]  io_log[$];
  logic        rdy_at_edge = 1'b0;
  logic [31:0] addr_trace [4];

  always #5 clk_in = ~clk_in;

  mem_ctrl dut (
    .clk_in              (clk_in),
    .rst_in              (rst_in),
    .rdy_in              (rdy_in),
    .read_mem            (read_mem),
    .write_mem           (write_mem),
    .mem_addr_to_read    (mem_addr_to_read),
    .mem_data_to_write   (mem_data_to_write),
    .data_len            (data_len),
    .mem_load_done       (mem_load_done),
    .mem_ctrl_busy_state (mem_ctrl_busy_state),
    .mem_ctrl_read_in    (mem_ctrl_read_in),
    .if_read             (if_read),
    .if_addr             (if_addr),
    .clear_in            (clear_in),
    .if_done             (if_done),
    .if_data             (if_data),
    .mem_din             (mem_din),
    .mem_dout            (mem_dout),
    .mem_a               (mem_a),
    .mem_wr              (mem_wr),
    .io_buffer_full      (io_buffer_full)
  );

  // Synchronous RAM in the same rdy domain; IO-space writes go to a log.
  always @(posedge clk_in) begin
    rdy_at_edge <= rdy_in;
    if (rdy_in) begin
      mem_din <= ram[mem_a[15:0]];
      if (mem_wr) begin
        if (mem_a[17]) io_log.push_back(mem_dout);
        else ram[mem_a[15:0]] <= mem_dout;
      end
    end
  end

  function automatic logic [31:0] ram_word(input logic [15:0] a);
    return {ram[a + 16'd3], ram[a + 16'd2], ram[a + 16'd1], ram[a]};
  endfunction

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  exp_t        mon_e;
  logic [31:0] mon_obs;
  always @(negedge clk_in) begin
    if (!rst_in && rdy_at_edge && (mem_load_done || if_done)) begin
      checks++;
      if (sb_q.size() == 0) begin
        $display("FAIL sb_done: got load_done=%b if_done=%b, want no pulse",
                 mem_load_done, if_done);
      end else begin
        mon_e   = sb_q.pop_front();
        mon_obs = if_done ? if_data : mem_ctrl_read_in;
        if (if_done !== mon_e.is_fetch || (mon_e.chk && mon_obs !== mon_e.data))
          $display("FAIL sb_data: got fetch=%b data=%h, want fetch=%b data=%h",
                   if_done, mon_obs, mon_e.is_fetch, mon_e.data);
        else passes++;
      end
    end
  end

  // Waits for a done pulse; lat = enabled edges from accept edge to done (-1 on timeout).
  task automatic wait_done(input int budget, output int lat, output logic [1:0] first_busy);
    lat        = -1;
    first_busy = 2'bxx;
    for (int n = 1; n <= budget; n++) begin
      @(negedge clk_in);
      if (n == 1) first_busy = mem_ctrl_busy_state;
      if (n <= 4) addr_trace[n-1] = mem_a;
      if (mem_load_done || if_done) begin
        lat = n - 1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_in = 1'b1; rdy_in = 1'b1; read_mem = 1'b0; write_mem = 1'b0; if_read = 1'b0;
    clear_in = 1'b0; io_buffer_full = 1'b0; mem_addr_to_read = '0; mem_data_to_write = '0;
    if_addr = '0; data_len = '0;
    repeat (2) @(negedge clk_in);
    checks++;
    if ({mem_load_done, if_done, mem_wr} !== 3'b000)
      $display("FAIL reset_flags: got %b, want 000", {mem_load_done, if_done, mem_wr});
    else passes++;
    checks++;
    if (mem_ctrl_busy_state !== 2'b00)
      $display("FAIL reset_busy: got %b, want 00", mem_ctrl_busy_state);
    else passes++;
    checks++;
    if ({mem_ctrl_read_in, if_data} !== 64'h0)
      $display("FAIL reset_data: got %h %h, want 0 0", mem_ctrl_read_in, if_data);
    else passes++;
    checks++;
    if ({mem_a, mem_dout} !== 40'h0)
      $display("FAIL reset_bus: got a=%h dout=%h, want 0 0", mem_a, mem_dout);
    else passes++;
    rst_in = 1'b0;
    @(negedge clk_in);
  endtask

  task automatic test_lw;
    int lat; logic [1:0] fb;
    sb_q.push_back('{is_fetch: 1'b0, chk: 1'b1, data: 32'h44332211});
    mem_addr_to_read = 32'h1000; data_len = 3'd4; read_mem = 1'b1;
    wait_done(30, lat, fb);
    read_mem = 1'b0;
    checks++;
    if (lat !== 5) $display("FAIL lw_latency: got %0d, want 5", lat); else passes++;
    checks++;
    if (fb !== 2'b10) $display("FAIL lw_busy: got %b, want 10", fb); else passes++;
    checks++;
    if (mem_ctrl_busy_state !== 2'b00)
      $display("FAIL lw_done_busy: got %b, want 00", mem_ctrl_busy_state);
    else passes++;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (addr_trace[k] !== 32'h1000 + k)
        $display("FAIL lw_addr%0d: got %h, want %h", k, addr_trace[k], 32'h1000 + k);
      else passes++;
    end
    @(negedge clk_in);
    checks++;
    if (mem_load_done !== 1'b0) $display("FAIL lw_pulse: got %b, want 0", mem_load_done);
    else passes++;
  endtask

  task automatic test_sh;
    int lat; logic [1:0] fb; logic [7:0] below, above;
    below = ram[16'h2001]; above = ram[16'h2004];
    sb_q.push_back('{is_fetch: 1'b0, chk: 1'b0, data: 32'h0});
    mem_addr_to_read = 32'h2002; mem_data_to_write = 32'hAABBCCDD; data_len = 3'd1;
    write_mem = 1'b1;
    wait_done(30, lat, fb);
    write_mem = 1'b0;
    checks++;
    if (lat !== 2) $display("FAIL sh_latency: got %0d, want 2", lat); else passes++;
    checks++;
    if (addr_trace[0] !== 32'h2002 || addr_trace[1] !== 32'h2003)
      $display("FAIL sh_addr: got %h %h, want 2002 2003", addr_trace[0], addr_trace[1]);
    else passes++;
    @(negedge clk_in);
    checks++;
    if (mem_wr !== 1'b0) $display("FAIL sh_wr_idle: got %b, want 0", mem_wr); else passes++;
    checks++;
    if ({ram[16'h2003], ram[16'h2002]} !== 16'hCCDD)
      $display("FAIL sh_data: got %h, want ccdd", {ram[16'h2003], ram[16'h2002]});
    else passes++;
    checks++;
    if (ram[16'h2001] !== below || ram[16'h2004] !== above)
      $display("FAIL sh_neighbours: got %h %h, want %h %h",
               ram[16'h2001], ram[16'h2004], below, above);
    else passes++;
  endtask

  task automatic test_arbitration;
    int lat; logic [1:0] fb;
    sb_q.push_back('{is_fetch: 1'b0, chk: 1'b1, data: {24'h0, ram[16'h0010]}});
    sb_q.push_back('{is_fetch: 1'b1, chk: 1'b1, data: ram_word(16'h0040)});
    mem_addr_to_read = 32'h10; data_len = 3'd1; read_mem = 1'b1;
    if_addr = 32'h40; if_read = 1'b1;
    wait_done(30, lat, fb);
    read_mem = 1'b0;
    checks++;
    if (lat !== 2 || fb !== 2'b10 || mem_load_done !== 1'b1)
      $display("FAIL arb_lb_first: got lat=%0d busy=%b done=%b, want 2 10 1",
               lat, fb, mem_load_done);
    else passes++;
    @(negedge clk_in);
    wait_done(30, lat, fb);
    if_read = 1'b0;
    checks++;
    if (lat !== 5 || fb !== 2'b11 || if_done !== 1'b1)
      $display("FAIL arb_fetch_next: got lat=%0d busy=%b done=%b, want 5 11 1",
               lat, fb, if_done);
    else passes++;
    @(negedge clk_in);
  endtask

  task automatic test_clear;
    int lat, seen; logic [1:0] fb;
    if_addr = 32'h100; if_read = 1'b1; clear_in = 1'b0;
    repeat (3) @(negedge clk_in);
    checks++;
    if (mem_a !== 32'h102) $display("FAIL clr_third_byte: got %h, want 102", mem_a);
    else passes++;
    clear_in = 1'b1; if_read = 1'b0;
    @(negedge clk_in);
    clear_in = 1'b0;
    checks++;
    if (mem_ctrl_busy_state !== 2'b00 || mem_wr !== 1'b0 || if_done !== 1'b0)
      $display("FAIL clr_idle: got busy=%b wr=%b done=%b, want 00 0 0",
               mem_ctrl_busy_state, mem_wr, if_done);
    else passes++;
    seen = 0;
    repeat (6) begin
      @(negedge clk_in);
      if (if_done) seen++;
    end
    checks++;
    if (seen !== 0) $display("FAIL clr_no_done: got %0d pulses, want 0", seen); else passes++;
    // A fetch raised together with a flush is not accepted.
    if_addr = 32'h0; if_read = 1'b1; clear_in = 1'b1;
    @(negedge clk_in);
    clear_in = 1'b0;
    checks++;
    if (mem_ctrl_busy_state !== 2'b00)
      $display("FAIL clr_reject: got %b, want 00", mem_ctrl_busy_state);
    else passes++;
    sb_q.push_back('{is_fetch: 1'b1, chk: 1'b1, data: ram_word(16'h0000)});
    wait_done(30, lat, fb);
    if_read = 1'b0;
    checks++;
    if (lat !== 5 || fb !== 2'b11)
      $display("FAIL clr_refetch: got lat=%0d busy=%b, want 5 11", lat, fb);
    else passes++;
    @(negedge clk_in);
  endtask

  task automatic test_rdy_pause;
    int lat; logic [1:0] fb;
    sb_q.push_back('{is_fetch: 1'b0, chk: 1'b1, data: 32'h44332211});
    mem_addr_to_read = 32'h1000; data_len = 3'd4; read_mem = 1'b1;
    repeat (2) @(negedge clk_in);
    rdy_in = 1'b0;
    repeat (3) @(negedge clk_in);
    rdy_in = 1'b1;
    wait_done(30, lat, fb);
    read_mem = 1'b0;
    // Two edges before the pause, three frozen edges, then the remaining ones.
    checks++;
    if (lat + 5 !== 8) $display("FAIL rdy_load_latency: got %0d, want 8", lat + 5);
    else passes++;
    @(negedge clk_in);
    sb_q.push_back('{is_fetch: 1'b0, chk: 1'b0, data: 32'h0});
    mem_addr_to_read = 32'h3000; mem_data_to_write = 32'h11223344; data_len = 3'd3;
    write_mem = 1'b1;
    @(negedge clk_in);
    checks++;
    if (mem_wr !== 1'b1) $display("FAIL rdy_wr_active: got %b, want 1", mem_wr); else passes++;
    rdy_in = 1'b0;
    #1;
    checks++;
    if (mem_wr !== 1'b0) $display("FAIL rdy_wr_forced: got %b, want 0", mem_wr); else passes++;
    repeat (2) @(negedge clk_in);
    rdy_in = 1'b1;
    wait_done(30, lat, fb);
    write_mem = 1'b0;
    checks++;
    if (lat !== 3) $display("FAIL rdy_store_latency: got %0d, want 3", lat); else passes++;
    @(negedge clk_in);
    checks++;
    if (ram_word(16'h3000) !== 32'h11223344)
      $display("FAIL rdy_store_data: got %h, want 11223344", ram_word(16'h3000));
    else passes++;
  endtask

  task automatic test_wrap;
    int lat; logic [1:0] fb;
    sb_q.push_back('{is_fetch: 1'b0, chk: 1'b1, data: {16'h0, ram[16'h0000], ram[16'hFFFF]}});
    mem_addr_to_read = 32'hFFFF_FFFF; data_len = 3'd2; read_mem = 1'b1;
    wait_done(30, lat, fb);
    read_mem = 1'b0;
    checks++;
    if (lat !== 3 || addr_trace[1] !== 32'h0)
      $display("FAIL wrap: got lat=%0d a1=%h, want 3 00000000", lat, addr_trace[1]);
    else passes++;
    @(negedge clk_in);
  endtask

  task automatic test_reset_mid_store;
    logic [7:0] old1;
    old1 = ram[16'h4001];
    mem_addr_to_read = 32'h4000; mem_data_to_write = 32'hCAFEF00D; data_len = 3'd3;
    write_mem = 1'b1;
    repeat (2) @(negedge clk_in);
    rst_in = 1'b1;
    #1;
    checks++;
    if (mem_wr !== 1'b0 || mem_ctrl_busy_state !== 2'b00)
      $display("FAIL rst_mid: got wr=%b busy=%b, want 0 00", mem_wr, mem_ctrl_busy_state);
    else passes++;
    write_mem = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b0;
    repeat (3) @(negedge clk_in);
    checks++;
    if (ram[16'h4000] !== 8'h0D || ram[16'h4001] !== old1)
      $display("FAIL rst_partial: got %h %h, want 0d %h", ram[16'h4000], ram[16'h4001], old1);
    else passes++;
  endtask

  task automatic test_io_store;
    int lat; logic [1:0] fb;
    io_log.delete();
    sb_q.push_back('{is_fetch: 1'b0, chk: 1'b0, data: 32'h0});
    mem_addr_to_read = 32'h30000; mem_data_to_write = 32'h0000005A; data_len = 3'd0;
    io_buffer_full = 1'b1; write_mem = 1'b1;
`ifdef MEMCTRL_IO_STALL_EN
    begin
      int wr_seen;
      wr_seen = 0;
      repeat (4) begin
        @(negedge clk_in);
        if (mem_wr) wr_seen++;
      end
      checks++;
      if (wr_seen !== 0) $display("FAIL io_stall: got %0d writes, want 0", wr_seen);
      else passes++;
      io_buffer_full = 1'b0;
      wait_done(30, lat, fb);
      checks++;
      if (lat !== 1) $display("FAIL io_resume: got %0d, want 1", lat); else passes++;
    end
`else
    wait_done(30, lat, fb);
    checks++;
    if (lat !== 1) $display("FAIL io_nostall: got %0d, want 1", lat); else passes++;
`endif
    write_mem = 1'b0; io_buffer_full = 1'b0;
    @(negedge clk_in);
    checks++;
    if (io_log.size() !== 1 || io_log[0] !== 8'h5A)
      $display("FAIL io_log: got %0d bytes first=%h, want 1 5a",
               io_log.size(), (io_log.size() > 0) ? io_log[0] : 8'h00);
    else passes++;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = 8'(i * 7 + 3);
    ram[16'h1000] = 8'h11; ram[16'h1001] = 8'h22; ram[16'h1002] = 8'h33; ram[16'h1003] = 8'h44;
    ram[16'h0010] = 8'h9C;
    test_reset();
    test_lw();
    test_sh();
    test_arbitration();
    test_clear();
    test_rdy_pause();
    test_wrap();
    test_reset_mid_store();
    test_io_store();
    repeat (2) @(negedge clk_in);
    checks++;
    if (sb_q.size() !== 0) $display("FAIL sb_drain: got %0d pending, want 0", sb_q.size());
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
